// File: rtl/fnd_scan_ctrl_if.sv
// Signal bundle between the BCD counter chain (master) and the FND scan controller (slave),
// including the display-side outputs toward the segment decoder and row pins.
interface fnd_scan_ctrl_if;
    logic [31:0] digits;
    logic [7:0]  dp_mask;
    logic        load;
    logic        lz_suppress;
    logic [3:0]  brightness;
    logic        busy;
    logic        frame_done;
    logic [3:0]  bcd_out;
    logic        seg_blank;
    logic        dp_out;
    logic [7:0]  fnd_row;

    modport master (
        output digits, dp_mask, load, lz_suppress, brightness,
        input  busy, frame_done, bcd_out, seg_blank, dp_out, fnd_row
    );

    modport slave (
        input  digits, dp_mask, load, lz_suppress, brightness,
        output busy, frame_done, bcd_out, seg_blank, dp_out, fnd_row
    );
endinterface

// File: rtl/fnd_scan_ctrl.sv
// Eight-digit multiplexed FND scan scheduler: frame-synchronous load, per-slot blanking guard,
// 4-bit PWM brightness and leading-zero suppression, with all display outputs registered.
module fnd_scan_ctrl #(
    parameter int SLOT_CYCLES  = 1024,
    parameter int BLANK_CYCLES = 64
) (
    input  logic           clk,
    input  logic           rst,
    fnd_scan_ctrl_if.slave bus
);
    localparam int            CW         = $clog2(SLOT_CYCLES);
    localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    typedef enum logic {
        PH_BLANK,
        PH_ON
    } phase_t;

    phase_t        phase;
    phase_t        phase_nxt;
    logic [CW-1:0] slot_cnt;
    logic [2:0]    dig_idx;
    logic          slot_end;
    logic          frame_end;

    logic [31:0]   stage_digits;
    logic [31:0]   shadow_digits;
    logic [7:0]    stage_dp;
    logic [7:0]    shadow_dp;
    logic          pending;

    logic          suppressed;
    logic [3:0]    bcd_nxt;
    logic          seg_blank_nxt;
    logic          dp_nxt;
    logic [7:0]    row_nxt;

    assign slot_end  = (slot_cnt == SLOT_LAST);
    assign frame_end = slot_end && (dig_idx == 3'd7);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt <= '0;
            dig_idx  <= '0;
        end else if (slot_end) begin
            slot_cnt <= '0;
            dig_idx  <= dig_idx + 3'd1;
        end else begin
            slot_cnt <= slot_cnt + CW'(1);
        end
    end

    // Phase FSM: state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= PH_BLANK;
        end else begin
            phase <= phase_nxt;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        phase_nxt = phase;
        case (phase)
            PH_BLANK: if (slot_cnt == BLANK_LAST) phase_nxt = PH_ON;
            PH_ON:    if (slot_end)               phase_nxt = PH_BLANK;
            default:                              phase_nxt = PH_BLANK;
        endcase
    end

    // NOTE: staging/shadow are plain flops, not a RAM, so they can and must reset to a blank display.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_digits  <= '0;
            stage_dp      <= '0;
            shadow_digits <= '0;
            shadow_dp     <= '0;
            pending       <= 1'b0;
        end else begin
            if (bus.load) begin
                stage_digits <= bus.digits;
                stage_dp     <= bus.dp_mask;
            end
            // A load landing exactly on the boundary skips staging and is shown next frame.
            if (frame_end && bus.load) begin
                shadow_digits <= bus.digits;
                shadow_dp     <= bus.dp_mask;
                pending       <= 1'b0;
            end else if (frame_end && pending) begin
                shadow_digits <= stage_digits;
                shadow_dp     <= stage_dp;
                pending       <= 1'b0;
            end else if (bus.load) begin
                pending <= 1'b1;
            end
        end
    end

    // Phase FSM: output decode, registered below so outputs lag state by one clock.
    always_comb begin
        suppressed    = bus.lz_suppress && (dig_idx != 3'd0) &&
                        ((shadow_digits >> {dig_idx, 2'b00}) == 32'd0);
        bcd_nxt       = shadow_digits[{dig_idx, 2'b00} +: 4];
        seg_blank_nxt = (phase == PH_BLANK) || suppressed;
        dp_nxt        = (phase == PH_ON) && shadow_dp[dig_idx];
        row_nxt       = '0;
        if ((phase == PH_ON) && (slot_cnt[3:0] <= bus.brightness)) begin
            row_nxt = 8'd1 << dig_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.bcd_out    <= '0;
            bus.seg_blank  <= 1'b1;
            bus.dp_out     <= 1'b0;
            bus.fnd_row    <= '0;
            bus.frame_done <= 1'b0;
        end else begin
            bus.bcd_out    <= bcd_nxt;
            bus.seg_blank  <= seg_blank_nxt;
            bus.dp_out     <= dp_nxt;
            bus.fnd_row    <= row_nxt;
            bus.frame_done <= frame_end;
        end
    end

    assign bus.busy = pending;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Scoreboard bench for fnd_scan_ctrl: stimulus queues hand-derived expectations keyed by clock
// number, a monitor samples DUT outputs on the falling edge and retires them.
module tb_fnd_scan_ctrl;
    localparam int SLOT  = 64;
    localparam int BLANK = 8;
    localparam int FRAME = 8 * SLOT;

    typedef enum {SIG_ROW, SIG_BLANK, SIG_BCD, SIG_DP, SIG_FD, SIG_BUSY} sig_e;

    typedef struct {
        int          tick;
        sig_e        sig;
        logic [31:0] val;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    fnd_scan_ctrl_if bus();

    fnd_scan_ctrl #(
        .SLOT_CYCLES  (SLOT),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   tick  = 0;
    int   base  = 0;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    always @(posedge clk) tick <= tick + 1;

    // Insert keeping the scoreboard ordered by the clock it must be checked at.
    task automatic push(input int t, input sig_e sig, input logic [31:0] val, input string name);
        exp_t e;
        int   i;
        e.tick = t;
        e.sig  = sig;
        e.val  = val;
        e.name = name;
        i = sb.size();
        while (i > 0 && sb[i-1].tick > t) i--;
        sb.insert(i, e);
    endtask

    task automatic pk(input int k, input sig_e sig, input logic [31:0] val, input string name);
        push(base + k, sig, val, name);
    endtask

    task automatic go(input int k);
        while (tick < base + k) @(negedge clk);
    endtask

    // Output k after release reflects state of clock k-1: slot s, digit d of frame f.
    task automatic expect_slot(input int f, input int d, input logic [3:0] bcd, input logic sup,
                               input logic dp, input logic [3:0] br, input string tag);
        for (int s = 0; s < SLOT; s++) begin
            int         k;
            logic [3:0] sl;
            k  = f * FRAME + d * SLOT + s + 1;
            sl = 4'(s);
            pk(k, SIG_ROW, (s >= BLANK && sl <= br) ? (32'd1 << d) : 32'd0,
               $sformatf("%s f%0d d%0d s%0d row", tag, f, d, s));
            pk(k, SIG_BLANK, (s < BLANK) ? 32'd1 : 32'(sup),
               $sformatf("%s f%0d d%0d s%0d blank", tag, f, d, s));
            pk(k, SIG_DP, (s >= BLANK) ? 32'(dp) : 32'd0,
               $sformatf("%s f%0d d%0d s%0d dp", tag, f, d, s));
            pk(k, SIG_BCD, 32'(bcd), $sformatf("%s f%0d d%0d s%0d bcd", tag, f, d, s));
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: retire every expectation due at this clock.
    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].tick <= tick) begin
                e = sb.pop_front();
                case (e.sig)
                    SIG_ROW:   act = 32'(bus.fnd_row);
                    SIG_BLANK: act = 32'(bus.seg_blank);
                    SIG_BCD:   act = 32'(bus.bcd_out);
                    SIG_DP:    act = 32'(bus.dp_out);
                    SIG_FD:    act = 32'(bus.frame_done);
                    SIG_BUSY:  act = 32'(bus.busy);
                    default:   act = 32'hx;
                endcase
                if (e.tick != tick) begin
                    total++;
                    bad++;
                    $display("FAIL %s: sampled at tick %0d, required tick %0d", e.name, tick, e.tick);
                end else begin
                    check(e.name, act, e.val);
                end
            end
        end
    end

    initial begin
        rst             = 1'b1;
        bus.digits      = '0;
        bus.dp_mask     = '0;
        bus.load        = 1'b0;
        bus.lz_suppress = 1'b0;
        bus.brightness  = 4'd15;
        repeat (3) @(negedge clk);
        push(tick + 1, SIG_ROW,   32'd0, "reset row");
        push(tick + 1, SIG_BLANK, 32'd1, "reset blank");
        push(tick + 1, SIG_BCD,   32'd0, "reset bcd");
        push(tick + 1, SIG_DP,    32'd0, "reset dp");
        push(tick + 1, SIG_FD,    32'd0, "reset frame_done");
        push(tick + 1, SIG_BUSY,  32'd0, "reset busy");
        @(negedge clk);
        rst  = 1'b0;
        base = tick;

        // Reset release: blank for 8 clocks, row 0 on clock 9, frame_done every 512 clocks.
        expect_slot(0, 0, 4'd0, 1'b0, 1'b0, 4'd15, "release");
        pk(1, SIG_BUSY, 32'd0, "release busy");
        pk(FRAME - 1, SIG_FD, 32'd0, "fd before first boundary");
        for (int f = 1; f <= 8; f++) begin
            pk(f * FRAME,     SIG_FD, 32'd1, $sformatf("fd pulse f%0d", f));
            pk(f * FRAME + 1, SIG_FD, 32'd0, $sformatf("fd clear f%0d", f));
        end

        // Leading-zero suppression, shown in frame 1.
        go(100);
        bus.digits      = 32'h0001_2345;
        bus.dp_mask     = 8'h04;
        bus.lz_suppress = 1'b1;
        bus.load        = 1'b1;
        pk(101, SIG_BUSY, 32'd1, "lz busy rise");
        pk(FRAME - 1, SIG_BUSY, 32'd1, "lz busy hold");
        pk(FRAME, SIG_BUSY, 32'd0, "lz busy fall");
        for (int d = 0; d < 8; d++) begin
            expect_slot(1, d, (d < 5) ? 4'(5 - d) : 4'd0, (d >= 5), (d == 2), 4'd15, "lz");
        end
        @(negedge clk);
        bus.load = 1'b0;

        // All-zero value with suppression (frame 2), then without (frame 3).
        go(FRAME + 300);
        bus.digits  = 32'h0;
        bus.dp_mask = 8'h00;
        bus.load    = 1'b1;
        pk(FRAME + 301, SIG_BUSY, 32'd1, "zero busy rise");
        pk(2 * FRAME - 1, SIG_BUSY, 32'd1, "zero busy hold");
        pk(2 * FRAME, SIG_BUSY, 32'd0, "zero busy fall");
        for (int d = 0; d < 8; d++) begin
            expect_slot(2, d, 4'd0, (d != 0), 1'b0, 4'd15, "zero_lz");
        end
        @(negedge clk);
        bus.load = 1'b0;
        go(3 * FRAME);
        bus.lz_suppress = 1'b0;
        for (int d = 0; d < 8; d++) begin
            expect_slot(3, d, 4'd0, 1'b0, 1'b0, 4'd15, "zero_nolz");
        end

        // Brightness 3 during frame 4.
        go(4 * FRAME);
        bus.brightness = 4'd3;
        for (int d = 0; d < 8; d++) begin
            expect_slot(4, d, 4'd0, 1'b0, 1'b0, 4'd3, "bright3");
        end

        // Two mid-frame loads in frame 5 (digits 3 and 5); last one wins in frame 6.
        go(5 * FRAME + 200);
        bus.brightness = 4'd15;
        bus.digits     = 32'h1111_1111;
        bus.load       = 1'b1;
        pk(5 * FRAME + 201, SIG_BUSY, 32'd1, "mid busy rise");
        @(negedge clk);
        bus.load = 1'b0;
        go(5 * FRAME + 330);
        bus.digits = 32'h2222_2222;
        bus.load   = 1'b1;
        pk(5 * FRAME + 331, SIG_BUSY, 32'd1, "mid busy after 2nd load");
        pk(6 * FRAME - 1, SIG_BUSY, 32'd1, "mid busy hold");
        pk(6 * FRAME, SIG_BUSY, 32'd0, "mid busy fall");
        for (int d = 0; d < 8; d++) begin
            expect_slot(6, d, 4'd2, 1'b0, 1'b0, 4'd15, "midload");
        end
        @(negedge clk);
        bus.load = 1'b0;

        // Load on the boundary cycle bypasses staging: shown in frame 7, busy never rises.
        go(7 * FRAME - 1);
        bus.digits  = 32'h8765_4321;
        bus.dp_mask = 8'h81;
        bus.load    = 1'b1;
        pk(7 * FRAME,      SIG_BUSY, 32'd0, "bypass busy @0");
        pk(7 * FRAME + 1,  SIG_BUSY, 32'd0, "bypass busy @1");
        pk(7 * FRAME + 20, SIG_BUSY, 32'd0, "bypass busy @20");
        for (int d = 0; d < 8; d++) begin
            expect_slot(7, d, 4'(d + 1), 1'b0, (d == 0 || d == 7), 4'd15, "bypass");
        end
        @(negedge clk);
        bus.load = 1'b0;

        // Reset during digit 4 ON of frame 8 with a load pending.
        go(8 * FRAME + 100);
        bus.digits = 32'h9999_9999;
        bus.load   = 1'b1;
        pk(8 * FRAME + 101, SIG_BUSY, 32'd1, "prereset busy rise");
        pk(8 * FRAME + 4 * SLOT + 19, SIG_BUSY, 32'd1, "prereset busy hold");
        pk(8 * FRAME + 4 * SLOT + 19, SIG_ROW, 32'h10, "prereset row d4");
        @(negedge clk);
        bus.load = 1'b0;
        go(8 * FRAME + 4 * SLOT + 20);
        rst        = 1'b1;
        bus.digits = 32'hAAAA_AAAA;
        bus.load   = 1'b1;
        push(tick + 1, SIG_ROW,   32'd0, "midreset row");
        push(tick + 1, SIG_BUSY,  32'd0, "midreset busy");
        push(tick + 1, SIG_BLANK, 32'd1, "midreset blank");
        push(tick + 1, SIG_BCD,   32'd0, "midreset bcd");
        push(tick + 1, SIG_DP,    32'd0, "midreset dp");
        @(negedge clk);
        rst      = 1'b0;
        bus.load = 1'b0;
        base     = tick;
        expect_slot(0, 0, 4'd0, 1'b0, 1'b0, 4'd15, "restart");
        expect_slot(0, 1, 4'd0, 1'b0, 1'b0, 4'd15, "restart");
        pk(1, SIG_BUSY, 32'd0, "restart busy (load with rst dropped)");
        pk(300, SIG_BUSY, 32'd0, "restart busy idle");
        pk(FRAME - 1, SIG_FD, 32'd0, "restart fd before boundary");
        pk(FRAME, SIG_FD, 32'd1, "restart fd pulse");
        go(FRAME + 4);

        for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            bad++;
            $display("FAIL scoreboard drain: got %0d entries left expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
